// File: rtl/fetch_unit_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, reset PC, bus size
// code and the instruction-buffer entry layout.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1C00_0000;
  localparam logic [1:0]  SIZE_WORD        = 2'b10;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // S_REQ: request phase, S_WAIT: accepted and awaiting data,
  // S_IDLE: buffer holds an ADEF entry, fetching stopped until redirect
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_IDLE = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_inst_buf.sv
// One-entry fetch-to-decode buffer with flush.
//   clk, reset       : clock, synchronous active-high reset
//   flush            : drop the held entry (redirect)
//   load, load_*     : write a new entry (takes effect next cycle)
//   ds_allowin       : decode consumes the entry this cycle
//   ready_c          : entry slot free or being drained this cycle
//   valid/pc/inst/adef : registered entry presented to decode
module fetch_inst_buf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  input  logic        load_adef,
  input  logic        ds_allowin,
  output logic        ready_c,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        adef
);

  fetch_entry_t entry;

  assign ready_c = !valid || ds_allowin;

  // Entry register: flush beats load, load beats drain; payload held on drain
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= '{pc: load_pc, inst: load_inst, adef: load_adef};
    end else if (valid && ds_allowin) begin
      valid <= 1'b0;
    end
  end

  assign pc   = entry.pc;
  assign inst = entry.inst;
  assign adef = entry.adef;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads on the SRAM-like bridge, keeps
// at most one request outstanding, and hands instructions to decode through
// a one-entry buffer. Redirects discard in-flight fetches.
//   clk, reset             : clock, synchronous active-high reset
//   inst_sram_*            : request/response bridge interface (read only)
//   redirect_valid/_pc     : branch/exception redirect pulse and target
//   ds_allowin             : decode accepts this cycle
//   fs_to_ds_*             : buffered instruction towards decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        fs_to_ds_adef
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  pend_pc, pend_pc_nxt;
  logic         pending, pending_nxt;
  logic         discard, discard_nxt;

  logic         buf_ready_c;
  logic         misaligned_c;
  logic         req_c;
  logic         accept_c;
  logic         buf_load_c;
  logic [31:0]  buf_pc_c;
  logic [31:0]  buf_inst_c;
  logic         buf_adef_c;

  assign misaligned_c = (pc[1:0] != 2'b00);
  // Once raised, req stays up until accepted: the buffer is empty from then on
  assign req_c        = !reset && (state == S_REQ) && !misaligned_c && buf_ready_c;
  assign accept_c     = req_c && inst_sram_addr_ok;

  assign inst_sram_req   = req_c;
  assign inst_sram_addr  = pc;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SIZE_WORD;
  assign inst_sram_wstrb = 4'b0;
  assign inst_sram_wdata = 32'b0;

  // State and fetch-pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      pend_pc <= 32'b0;
      pending <= 1'b0;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      pend_pc <= pend_pc_nxt;
      pending <= pending_nxt;
      discard <= discard_nxt;
    end
  end

  // Next-state, fetch pointer and buffer write control
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pend_pc_nxt = pend_pc;
    pending_nxt = pending;
    discard_nxt = discard;
    buf_load_c  = 1'b0;
    buf_pc_c    = pc;
    buf_inst_c  = 32'b0;
    buf_adef_c  = 1'b0;

    case (state)
      S_REQ: begin
        if (accept_c) begin
          // A redirect now or during the hold turns this request into a discard
          state_nxt   = S_WAIT;
          discard_nxt = pending || redirect_valid;
          pending_nxt = 1'b0;
          if (redirect_valid)  pc_nxt = redirect_pc;
          else if (pending)    pc_nxt = pend_pc;
          else                 pc_nxt = pc + PC_STEP;
        end else if (redirect_valid) begin
          // Held request must keep its address, so park the target
          if (req_c) begin
            pending_nxt = 1'b1;
            pend_pc_nxt = redirect_pc;
          end else begin
            pc_nxt = redirect_pc;
          end
        end else if (misaligned_c && buf_ready_c) begin
          buf_load_c = 1'b1;
          buf_adef_c = 1'b1;
          state_nxt  = S_IDLE;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          state_nxt   = S_REQ;
          discard_nxt = 1'b0;
          if (!discard && !redirect_valid) begin
            // pc already stepped past the in-flight address at acceptance
            buf_load_c = 1'b1;
            buf_pc_c   = pc - PC_STEP;
            buf_inst_c = inst_sram_rdata;
          end
        end else if (redirect_valid) begin
          discard_nxt = 1'b1;
        end
        if (redirect_valid) pc_nxt = redirect_pc;
      end
      S_IDLE: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  fetch_inst_buf u_inst_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .load       (buf_load_c),
    .load_pc    (buf_pc_c),
    .load_inst  (buf_inst_c),
    .load_adef  (buf_adef_c),
    .ds_allowin (ds_allowin),
    .ready_c    (buf_ready_c),
    .valid      (fs_to_ds_valid),
    .pc         (fs_to_ds_pc),
    .inst       (fs_to_ds_inst),
    .adef       (fs_to_ds_adef)
  );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1C00_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port inst_sram_req  output  1  fetch request valid.
REQ-005 SHALL have port inst_sram_wr  output  1  write flag, constant 0.
REQ-006 SHALL have port inst_sram_size  output  2  access size, constant 2'b10 (word).
REQ-007 SHALL have port inst_sram_wstrb  output  4  byte strobe, constant 4'b0.
REQ-008 SHALL have port inst_sram_addr  output  32  fetch address.
REQ-009 SHALL have port inst_sram_wdata  output  32  write data, constant 0.
REQ-010 SHALL have port inst_sram_addr_ok  input  1  request accepted by the bridge.
REQ-011 SHALL have port inst_sram_data_ok  input  1  instruction data returned.
REQ-012 SHALL have port inst_sram_rdata  input  32  returned instruction.
REQ-013 SHALL have port redirect_valid  input  1  branch/exception redirect, single-cycle pulse.
REQ-014 SHALL have port redirect_pc  input  32  redirect target.
REQ-015 SHALL have port ds_allowin  input  1  decode stage accepts this cycle.
REQ-016 SHALL have port fs_to_ds_valid  output  1  instruction buffer valid.
REQ-017 SHALL have port fs_to_ds_pc  output  32  PC of buffered instruction.
REQ-018 SHALL have port fs_to_ds_inst  output  32  buffered instruction.
REQ-019 SHALL have port fs_to_ds_adef  output  1  buffered entry carries an address-error (ADEF) exception.

Function
REQ-020 SHALL implement FSM states S_REQ (req high), S_WAIT (addr accepted, awaiting data_ok), S_IDLE (buffer full, no request).
REQ-021 SHALL hold inst_sram_addr stable while inst_sram_req=1 and inst_sram_addr_ok=0.
REQ-022 SHALL enter S_REQ only when buffer empty or being drained (fs_to_ds_valid && ds_allowin) this cycle; at most one request outstanding.
REQ-023 S_REQ -> S_WAIT on addr_ok; S_WAIT -> S_REQ or S_IDLE (per REQ-022) on data_ok.
REQ-024 On non-discarded data_ok, SHALL load buffer {pc, rdata, adef=0} and assert fs_to_ds_valid next cycle; pc advances by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-025 Buffer SHALL hold valid/pc/inst unchanged until ds_allowin=1, then clear unless refilled the same cycle.
REQ-026 If fetch pc[1:0] != 0, SHALL issue no bus request and load buffer {pc, 32'h0, adef=1} directly; fetching stops until redirect.
REQ-027 On redirect_valid: buffer cleared next cycle; next pc = redirect_pc; any outstanding or just-accepted request marked discard.
REQ-028 Redirect while req=1 without addr_ok: request stays held (REQ-021); redirect_pc latched in pending register; held request discarded once accepted.
REQ-029 Discarded request's data_ok SHALL be dropped (no buffer load), then fetch of redirect target begins the next cycle.
REQ-030 Redirect coinciding with data_ok SHALL drop that data; redirect coinciding with addr_ok SHALL discard that request.
REQ-031 Second redirect before discard completes SHALL overwrite the pending target; only the latest target is fetched.
REQ-032 Latency: data_ok in cycle N -> fs_to_ds_valid=1 in cycle N+1; next req earliest in N+1.

Reset
REQ-033 With reset=1 at a clock edge: state=S_REQ, pc=RESET_PC, fs_to_ds_valid=0, fs_to_ds_pc=0, fs_to_ds_inst=0, fs_to_ds_adef=0, discard=0, pending=0.
REQ-034 inst_sram_req SHALL be 0 while reset=1 and 1 in the first cycle after deassertion with addr=RESET_PC.
REQ-035 Reset mid-transaction SHALL abandon the outstanding request; a data_ok arriving after reset SHALL be ignored via discard.

Structure
REQ-036 FSM state encodings, RESET_PC default and SIZE_WORD constant SHALL live in the shared CPU package.
REQ-037 Instruction buffer SHALL be one sub-module, fetch_inst_buf (one-entry valid/ready register with flush).

Verification
REQ-038 Reset release, bridge addr_ok/data_ok same-cycle, rdata=32'h02800C0C, ds_allowin=1 -> req addr 1C000000, buffer {1C000000, 02800C0C} one cycle after data_ok, next req 1C000004.
REQ-039 ds_allowin=0 for 5 cycles with buffer full -> fs_to_ds_* constant, req=0; release -> req 1C000004 same cycle.
REQ-040 Redirect to 1C000100 in S_WAIT, data_ok 3 cycles later -> data dropped, valid stays 0, next req addr 1C000100.
REQ-041 Redirect to 1C000200 while req held without addr_ok for 4 cycles -> addr unchanged until accepted, its data dropped, then req 1C000200.
REQ-042 Redirect to 1C000302 -> no request, buffer {1C000302, 0, adef=1}.
REQ-043 Redirect to FFFFFFFC then accept -> following req addr 00000000.
